// File: rtl/contador_vecinos.sv
// Neighbour-bomb counter for the minesweeper board: snapshots the placed board and
// sweeps it one cell per clock, writing each cell's neighbour count and tallying bombs.
module contador_vecinos #(
    parameter int FILAS       = 8,
    parameter int COLUMNAS    = 8,
    parameter int ANCHO_CELDA = 9,
    parameter int BIT_BOMBA   = 2
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    input  logic [FILAS-1:0][COLUMNAS-1:0][ANCHO_CELDA-1:0] matriz_entrada,
    output logic [FILAS-1:0][COLUMNAS-1:0][ANCHO_CELDA-1:0] matriz_salida,
    output logic [6:0]                                      bombas_contadas,
    output logic                                            busy,
    output logic                                            done,
    output logic [1:0]                                      estado
);

    localparam int CELDAS      = FILAS * COLUMNAS;
    localparam int IW          = $clog2(CELDAS);
    localparam int FW          = $clog2(FILAS);
    localparam int CW          = $clog2(COLUMNAS);
    localparam int CUENTA_LSB  = 3;

    typedef enum logic [1:0] {IDLE, CARGA, BARRIDO, FIN} estado_t;

    estado_t estado_q, estado_d;

    logic [FILAS-1:0][COLUMNAS-1:0][ANCHO_CELDA-1:0] snapshot;
    logic [IW-1:0]          idx;
    int                     fila, columna, r, c;
    logic [FW-1:0]          fila_sel;
    logic [CW-1:0]          col_sel;
    logic [3:0]             cuenta;
    logic                   bomba_celda;
    logic [ANCHO_CELDA-1:0] celda_nueva;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) estado_q <= IDLE;
        else      estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:    if (start) estado_d = CARGA;
            CARGA:   estado_d = BARRIDO;
            BARRIDO: if (idx == IW'(CELDAS - 1)) estado_d = FIN;
            FIN:     estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    assign busy   = (estado_q == CARGA) || (estado_q == BARRIDO);
    assign estado = estado_q;

    // Neighbour sum over the 3x3 window; off-board positions simply contribute nothing.
    always_comb begin
        fila     = int'(idx) / COLUMNAS;
        columna  = int'(idx) % COLUMNAS;
        fila_sel = FW'(fila);
        col_sel  = CW'(columna);
        cuenta   = '0;
        r        = 0;
        c        = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = fila + dr;
                c = columna + dc;
                if (!(dr == 0 && dc == 0) && r >= 0 && r < FILAS && c >= 0 && c < COLUMNAS)
                    cuenta = cuenta + 4'(snapshot[FW'(r)][CW'(c)][BIT_BOMBA]);
            end
        end
        bomba_celda = snapshot[fila_sel][col_sel][BIT_BOMBA];
        celda_nueva = snapshot[fila_sel][col_sel];
        celda_nueva[CUENTA_LSB +: 4] = bomba_celda ? 4'd0 : cuenta;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snapshot        <= '0;
            matriz_salida   <= '0;
            bombas_contadas <= '0;
            idx             <= '0;
            done            <= 1'b0;
        end else begin
            done <= (estado_q == FIN);
            case (estado_q)
                CARGA: begin
                    snapshot        <= matriz_entrada;
                    bombas_contadas <= '0;
                    idx             <= '0;
                end
                BARRIDO: begin
                    matriz_salida[fila_sel][col_sel] <= celda_nueva;
                    bombas_contadas <= bombas_contadas + 7'(bomba_celda);
                    idx             <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_contador_vecinos.sv
// Bench for contador_vecinos: directed and random boards through a table, a scoreboard
// queue of expected boards, and hand sequences for reset and ignored-start corners.
module tb_contador_vecinos;

    typedef logic [7:0][7:0][8:0] board_t;
    localparam int RW = 576 + 7;

    typedef struct {
        string      name;
        board_t     in;
        logic [6:0] bombs;
    } vec_t;

    typedef struct {
        int         v;
        int         f;
        int         c;
        logic [8:0] val;
    } spot_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    board_t     matriz_entrada = '0;
    board_t     matriz_salida;
    logic [6:0] bombas_contadas;
    logic       busy, done;
    logic [1:0] estado;

    int total = 0;
    int bad   = 0;
    logic [RW-1:0] exp_q[$];

    vec_t  vecs[4];
    spot_t spots[14];

    contador_vecinos dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .matriz_entrada (matriz_entrada),
        .matriz_salida  (matriz_salida),
        .bombas_contadas(bombas_contadas),
        .busy           (busy),
        .done           (done),
        .estado         (estado)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_board(input string name, input board_t act, input board_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            for (int f = 0; f < 8; f++)
                for (int c = 0; c < 8; c++)
                    if (act[f][c] !== exp[f][c]) begin
                        $display("FAIL %s: cell [%0d][%0d] got %h expected %h", name, f, c,
                                 act[f][c], exp[f][c]);
                        return;
                    end
        end
    endtask

    // Reference: zero-padded 10x10 bomb map, 3x3 box sum minus the centre.
    function automatic board_t modelo(input board_t b);
        bit     p[10][10];
        board_t o;
        int     s;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++) p[i][j] = 1'b0;
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 8; c++) p[f+1][c+1] = b[f][c][2];
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 8; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) s += int'(p[f+i][c+j]);
                s -= int'(p[f+1][c+1]);
                o[f][c] = b[f][c];
                o[f][c][6:3] = b[f][c][2] ? 4'd0 : 4'(s);
            end
        return o;
    endfunction

    function automatic int cuenta_bombas(input board_t b);
        int n = 0;
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 8; c++) n += int'(b[f][c][2]);
        return n;
    endfunction

    // Starts one sweep of board a; optionally presents board bb with a start pulse at cycle cambio_en.
    task automatic run_case(input string name, input board_t a, input logic [6:0] exp_bombs,
                            input int cambio_en, input board_t bb, output board_t res);
        int            first;
        int            pulsos;
        logic [RW-1:0] e;
        @(negedge clk);
        matriz_entrada = a;
        start = 1'b1;
        exp_q.push_back({modelo(a), exp_bombs});
        @(negedge clk);
        start = 1'b0;
        chk_val({name, "_busy_carga"}, busy, 1);
        first  = -1;
        pulsos = 0;
        res    = '0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == cambio_en) begin
                matriz_entrada = bb;
                start = 1'b1;
            end
            if (done) begin
                pulsos++;
                if (first < 0) begin
                    first = cyc;
                    res   = matriz_salida;
                    e     = exp_q.pop_front();
                    chk_board({name, "_board"}, matriz_salida, e[RW-1:7]);
                    chk_val({name, "_bombas"}, bombas_contadas, e[6:0]);
                    chk_val({name, "_busy_done"}, busy, 0);
                end
            end
        end
        start = 1'b0;
        chk_val({name, "_latency"}, first, 66);
        chk_val({name, "_pulses"}, pulsos, 1);
        if (first < 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    board_t centro, esquina, anillo, aleatorio, res;
    int     pulsos_reset;

    initial begin
        centro = '0;
        centro[3][4] = 9'h004;
        esquina = '0;
        esquina[0][0] = 9'h004;
        anillo = '0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) anillo[4+dr][4+dc] = 9'h004;
        anillo[4][4] = 9'h003;
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 8; c++) begin
                aleatorio[f][c] = 9'($urandom_range(0, 511));
                aleatorio[f][c][2] = ($urandom_range(0, 3) == 0);
            end

        vecs[0] = '{"centro", centro, 7'd1};
        vecs[1] = '{"esquina", esquina, 7'd1};
        vecs[2] = '{"anillo", anillo, 7'd8};
        vecs[3] = '{"aleatorio", aleatorio, 7'(cuenta_bombas(aleatorio))};

        spots[0]  = '{0, 3, 4, 9'h004};
        spots[1]  = '{0, 2, 3, 9'h008};
        spots[2]  = '{0, 4, 5, 9'h008};
        spots[3]  = '{0, 3, 5, 9'h008};
        spots[4]  = '{0, 5, 4, 9'h000};
        spots[5]  = '{1, 0, 1, 9'h008};
        spots[6]  = '{1, 1, 0, 9'h008};
        spots[7]  = '{1, 1, 1, 9'h008};
        spots[8]  = '{1, 0, 7, 9'h000};
        spots[9]  = '{1, 7, 0, 9'h000};
        spots[10] = '{1, 7, 7, 9'h000};
        spots[11] = '{2, 4, 4, 9'h043};
        spots[12] = '{2, 3, 3, 9'h004};
        spots[13] = '{2, 5, 5, 9'h004};

        // Reset held: start must be ignored and all outputs stay zero.
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 8; c++) matriz_entrada[f][c] = 9'($urandom_range(0, 511));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_done", done, 0);
        chk_val("rst_bombas", bombas_contadas, 0);
        chk_board("rst_board", matriz_salida, '0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk_val("post_rst_busy", busy, 0);
        chk_val("post_rst_done", done, 0);
        chk_val("post_rst_bombas", bombas_contadas, 0);
        chk_board("post_rst_board", matriz_salida, '0);

        for (int v = 0; v < 4; v++) begin
            run_case(vecs[v].name, vecs[v].in, vecs[v].bombs, 0, '0, res);
            for (int s = 0; s < 14; s++)
                if (spots[s].v == v)
                    chk_val($sformatf("%s_spot_%0d_%0d", vecs[v].name, spots[s].f, spots[s].c),
                            32'(res[spots[s].f][spots[s].c]), 32'(spots[s].val));
        end

        // Second start with a different board mid-sweep must be ignored.
        run_case("snapshot", centro, 7'd1, 10, esquina, res);
        chk_val("snapshot_centre", 32'(res[3][4]), 32'h004);

        // Reset mid-sweep: outputs clear at once, no done, then a clean restart.
        @(negedge clk);
        matriz_entrada = centro;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk_val("pre_abort_partial", 32'(matriz_salida[2][4]), 32'h008);
        rst = 1'b0;
        #1;
        chk_val("abort_busy", busy, 0);
        chk_val("abort_done", done, 0);
        chk_val("abort_bombas", bombas_contadas, 0);
        chk_board("abort_board", matriz_salida, '0);
        pulsos_reset = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) pulsos_reset++;
        end
        chk_val("abort_no_done", pulsos_reset, 0);
        chk_val("abort_idle_busy", busy, 0);
        run_case("restart", centro, 7'd1, 0, '0, res);
        chk_val("restart_spot", 32'(res[4][3]), 32'h008);

        chk_val("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
